// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: base opcodes, immediate formats, ID/EX register layout.
// Pure declarations and small decode helpers; no state.
// Used by operand_stage and imm_gen (the branch unit reuses imm_gen as well).
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_type_e;

  // Contents of the ID/EX pipeline register (valid bit kept separately).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        rd_we;
    logic        is_load;
    logic        illegal;
  } idex_t;

  // Immediate format implied by the opcode.
  function automatic imm_type_e imm_type_of(input logic [6:0] opc);
    imm_type_e t;
    case (opc)
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: t = IMM_I;
      OPC_STORE:                                  t = IMM_S;
      OPC_BRANCH:                                 t = IMM_B;
      OPC_LUI, OPC_AUIPC:                         t = IMM_U;
      OPC_JAL:                                    t = IMM_J;
      default:                                    t = IMM_NONE;
    endcase
    return t;
  endfunction

  // True for the eleven RV32I base opcodes (low two bits are 2'b11 in all of them).
  function automatic logic is_rv32i_opcode(input logic [6:0] opc);
    logic ok;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: ok = 1'b1;
      default:                                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator: sign-extended immediate selected by opcode format.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows instr directly.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  imm_type_e imm_type;

  assign imm_type = imm_type_of(instr[6:0]);

  // Reassemble the scattered immediate bits for each format; bit 31 is always the sign.
  always_comb begin
    imm = 32'd0;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'd0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/operand_stage.sv
// Decode/operand fetch into the ID/EX register, with WB bypass and load-use bubble.
// Latency: one cycle accept-to-out_valid. Optional OPERAND_STAGE_ILLEGAL_DETECT_EN flags non-RV32I opcodes.
// Backpressure: in_ready drops while ID/EX is held (out_valid && !out_ready), on a load-use hazard, or on flush.
module operand_stage
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  input  logic [31:0] rf_data1,
  input  logic [31:0] rf_data2,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic        out_rd_we,
  output logic        out_is_load,
  output logic        out_illegal
);

  logic        valid_q;
  idex_t       idex_q;
  idex_t       idex_d;

  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        use_rs1;
  logic        use_rs2;
  logic        writes_rd;
  logic        illegal;
  logic        advance;
  logic        hazard;

  assign opc = in_instr[6:0];
  assign rd  = in_instr[11:7];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];

  imm_gen u_imm_gen (
    .instr (in_instr),
    .imm   (imm)
  );

`ifdef OPERAND_STAGE_ILLEGAL_DETECT_EN
  assign illegal = (in_instr[1:0] != 2'b11) || !is_rv32i_opcode(opc);
`else
  assign illegal = 1'b0;
`endif

  // Source-register usage per opcode; only real reads can create a load-use stall.
  always_comb begin
    use_rs1   = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    use_rs2   = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    writes_rd = (opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL) ||
                (opc == OPC_JALR) || (opc == OPC_LOAD) || (opc == OPC_OP_IMM) ||
                (opc == OPC_OP);
  end

  assign advance = !valid_q || out_ready;

  // A load still sitting in ID/EX cannot forward its data yet, so the consumer waits one cycle.
  assign hazard = valid_q && idex_q.is_load && (idex_q.rd != 5'd0) &&
                  ((use_rs1 && (idex_q.rd == rs1)) || (use_rs2 && (idex_q.rd == rs2)));

  assign in_ready = reset_n && !flush && advance && !hazard;

  // Next ID/EX contents; operands take the WB bypass so a same-cycle write is seen.
  always_comb begin
    idex_d         = '0;
    idex_d.pc      = in_pc;
    idex_d.instr   = in_instr;
    idex_d.rs1     = rs1;
    idex_d.rs2     = rs2;
    idex_d.rd      = rd;
    idex_d.imm     = imm;
    idex_d.illegal = illegal;
    idex_d.rd_we   = writes_rd && (rd != 5'd0) && !illegal;
    idex_d.is_load = (opc == OPC_LOAD) && !illegal;

    if (rs1 == 5'd0)                      idex_d.rs1_val = 32'd0;
    else if (wb_we && (wb_rd == rs1))     idex_d.rs1_val = wb_data;
    else                                  idex_d.rs1_val = rf_data1;

    if (rs2 == 5'd0)                      idex_d.rs2_val = 32'd0;
    else if (wb_we && (wb_rd == rs2))     idex_d.rs2_val = wb_data;
    else                                  idex_d.rs2_val = rf_data2;
  end

  // ID/EX register: reset, flush, bubble, capture, drain, else hold.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (advance && hazard) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      idex_q  <= idex_d;
    end else if (advance) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = idex_q.pc;
  assign out_instr   = idex_q.instr;
  assign out_rs1_val = idex_q.rs1_val;
  assign out_rs2_val = idex_q.rs2_val;
  assign out_rs1     = idex_q.rs1;
  assign out_rs2     = idex_q.rs2;
  assign out_rd      = idex_q.rd;
  assign out_imm     = idex_q.imm;
  assign out_rd_we   = idex_q.rd_we;
  assign out_is_load = idex_q.is_load;
  assign out_illegal = idex_q.illegal;

endmodule

// File: tb/tb_operand_stage.sv
// Directed self-checking bench for operand_stage.
// Inputs change 1ns after the rising edge; registered outputs are checked there too.
// Build with +define+OPERAND_STAGE_ILLEGAL_DETECT_EN to check the illegal-detect variant.
module tb_operand_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rf_data1;
  logic [31:0] rf_data2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_rd_we;
  logic        out_is_load;
  logic        out_illegal;

  int errors = 0;
  int checks = 0;

  operand_stage dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .rs1         (rs1),
    .rs2         (rs2),
    .rf_data1    (rf_data1),
    .rf_data2    (rf_data2),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_rs1_val (out_rs1_val),
    .out_rs2_val (out_rs2_val),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_imm     (out_imm),
    .out_rd_we   (out_rd_we),
    .out_is_load (out_is_load),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h40;
    out_ready = 1'b1; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; rf_data1 = 32'h1; rf_data2 = 32'h2;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (out_imm !== 32'd0) begin errors++; $display("FAIL reset_out_imm got=%h exp=0", out_imm); end
    checks++; if (out_rd_we !== 1'b0) begin errors++; $display("FAIL reset_out_rd_we got=%0b exp=0", out_rd_we); end
    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100; rf_data1 = 32'h1234; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got=%0b exp=1", out_valid); end
    checks++; if (out_imm !== 32'd5) begin errors++; $display("FAIL addi_imm got=%h exp=5", out_imm); end
    checks++; if (out_rd !== 5'd1) begin errors++; $display("FAIL addi_rd got=%0d exp=1", out_rd); end
    checks++; if (out_rd_we !== 1'b1) begin errors++; $display("FAIL addi_rd_we got=%0b exp=1", out_rd_we); end
    checks++; if (out_rs1_val !== 32'd0) begin errors++; $display("FAIL addi_rs1_val got=%h exp=0", out_rs1_val); end
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL addi_pc got=%h exp=100", out_pc); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_bypass();
    // add x4,x3,x3 while WB writes x3 in the same cycle
    in_valid = 1'b1; in_instr = 32'h00318233; rf_data1 = 32'd0; rf_data2 = 32'd0;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    #1;
    checks++; if (rs1 !== 5'd3 || rs2 !== 5'd3) begin errors++; $display("FAIL bypass_rs_addr got=%0d/%0d exp=3/3", rs1, rs2); end
    tick();
    checks++; if (out_rs1_val !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs1 got=%h exp=deadbeef", out_rs1_val); end
    checks++; if (out_rs2_val !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs2 got=%h exp=deadbeef", out_rs2_val); end
    // same instruction, WB to another register: register-file data is used
    wb_rd = 5'd7; rf_data1 = 32'h11; rf_data2 = 32'h22;
    tick();
    wb_we = 1'b0; in_valid = 1'b0;
    checks++; if (out_rs1_val !== 32'h11 || out_rs2_val !== 32'h22) begin errors++; $display("FAIL nobypass_vals got=%h/%h exp=11/22", out_rs1_val, out_rs2_val); end
    checks++; if (out_rd !== 5'd4 || out_rd_we !== 1'b1) begin errors++; $display("FAIL add_rd got=%0d/%0b exp=4/1", out_rd, out_rd_we); end
  endtask

  task automatic test_load_use();
    in_valid = 1'b1; in_instr = 32'h0000A283; in_pc = 32'h200;  // lw x5,0(x1)
    tick();
    checks++; if (out_is_load !== 1'b1 || out_rd !== 5'd5) begin errors++; $display("FAIL lw_capture got=%0b/%0d exp=1/5", out_is_load, out_rd); end
    in_instr = 32'h00028333; in_pc = 32'h204; rf_data1 = 32'h55;  // add x6,x5,x0
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_in_ready got=%0b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hazard_bubble got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_bubble_in_ready got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00028333) begin errors++; $display("FAIL dep_issue got=%0b/%h exp=1/00028333", out_valid, out_instr); end
    checks++; if (out_rs1_val !== 32'h55 || out_rd !== 5'd6) begin errors++; $display("FAIL dep_fields got=%h/%0d exp=55/6", out_rs1_val, out_rd); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_instr = 32'hFE20AE23; in_pc = 32'h300;  // sw x2,-4(x1)
    #1;
    checks++; if (rs1 !== 5'd1 || rs2 !== 5'd2) begin errors++; $display("FAIL sw_rs_addr got=%0d/%0d exp=1/2", rs1, rs2); end
    tick();
    out_ready = 1'b0; in_instr = 32'h00500093; in_pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%0b exp=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_instr !== 32'hFE20AE23 || out_pc !== 32'h300) begin errors++; $display("FAIL stall_hold cyc=%0d got=%0b/%h/%h", i, out_valid, out_instr, out_pc); end
      checks++; if (out_imm !== 32'hFFFFFFFC || out_rd_we !== 1'b0) begin errors++; $display("FAIL stall_imm cyc=%0d got=%h/%0b exp=fffffffc/0", i, out_imm, out_rd_we); end
      tick();
    end
  endtask

  task automatic test_flush();
    // still holding sw with out_ready low; flush together with a presented instruction
    flush = 1'b1; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill got=%0b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept got=%0b exp=0", out_valid); end
  endtask

  task automatic test_imm_types();
    logic [31:0] vec_instr [4];
    logic [31:0] vec_imm   [4];
    logic        vec_we    [4];
    vec_instr[0] = 32'h123453B7; vec_imm[0] = 32'h12345000; vec_we[0] = 1'b1;  // lui x7,0x12345
    vec_instr[1] = 32'hFF9FF0EF; vec_imm[1] = 32'hFFFFFFF8; vec_we[1] = 1'b1;  // jal x1,-8
    vec_instr[2] = 32'hFE000EE3; vec_imm[2] = 32'hFFFFFFFC; vec_we[2] = 1'b0;  // beq x0,x0,-4
    vec_instr[3] = 32'h00000000; vec_imm[3] = 32'h00000000; vec_we[3] = 1'b0;  // illegal opcode
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = vec_instr[i];
      tick();
      checks++; if (out_valid !== 1'b1 || out_imm !== vec_imm[i]) begin errors++; $display("FAIL imm_vec%0d got=%0b/%h exp=1/%h", i, out_valid, out_imm, vec_imm[i]); end
      checks++; if (out_rd_we !== vec_we[i]) begin errors++; $display("FAIL rd_we_vec%0d got=%0b exp=%0b", i, out_rd_we, vec_we[i]); end
    end
    in_valid = 1'b0;
`ifdef OPERAND_STAGE_ILLEGAL_DETECT_EN
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got=%0b exp=1", out_illegal); end
`else
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL illegal_flag got=%0b exp=0", out_illegal); end
`endif
    checks++; if (out_is_load !== 1'b0) begin errors++; $display("FAIL illegal_is_load got=%0b exp=0", out_is_load); end
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_load_use();
    test_backpressure();
    test_flush();
    test_imm_types();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
# operand_stage

Decode/operand-fetch pipeline stage that sits directly upstream of the register file in the RV32I pipeline. It accepts fetched instructions, drives the register-file read addresses, and captures the read data with a writeback bypass. It generates the immediate and detects load-use hazards, holding the result in the ID/EX pipeline register. A valid/ready handshake runs on both sides.

## Interface
- No parameters (XLEN fixed at 32).
- `clk`  in  1  clock, all state on rising edge
- `reset_n`  in  1  synchronous reset, active-low
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  stage accepts the instruction this cycle
- `in_instr`  in  32  instruction word
- `in_pc`  in  32  instruction PC
- `rs1`, `rs2`  out  5  register-file read addresses, combinational from `in_instr[19:15]` / `in_instr[24:20]`
- `rf_data1`, `rf_data2`  in  32  register-file combinational read data
- `wb_we`  in  1  writeback write enable
- `wb_rd`  in  5  writeback destination
- `wb_data`  in  32  writeback data
- `flush`  in  1  kill the held instruction and any accept this cycle
- `out_valid`  out  1  ID/EX register holds a live instruction
- `out_ready`  in  1  execute stage consumes it
- `out_pc`, `out_instr`  out  32  captured PC / raw instruction
- `out_rs1_val`, `out_rs2_val`  out  32  operand values
- `out_rs1`, `out_rs2`, `out_rd`  out  5  register indices (for downstream forwarding)
- `out_imm`  out  32  sign-extended immediate
- `out_rd_we`  out  1  instruction writes `rd` (forced 0 when `rd`=0)
- `out_is_load`  out  1  opcode LOAD
- `out_illegal`  out  1  illegal opcode flag (see Configuration)

## Operation
- `advance` = `!out_valid || out_ready`.
- `hazard` = `out_valid && out_is_load && out_rd!=0 && ((use_rs1 && out_rd==rs1) || (use_rs2 && out_rd==rs2))`.
- `use_rs1`: every opcode except LUI, AUIPC, JAL. `use_rs2`: OP, STORE, BRANCH only.
- `in_ready` = `reset_n && !flush && advance && !hazard`.
- Priority at each clock edge:
  1. `!reset_n`: clear all registers.
  2. `flush`: `out_valid`<=0.
  3. `advance && hazard`: insert a bubble, `out_valid`<=0.
  4. `in_valid && in_ready`: capture all fields, `out_valid`<=1.
  5. Otherwise, if `advance`: `out_valid`<=0.
  6. Otherwise: hold every output.
- Operand capture: if `wb_we && wb_rd==rsX && rsX!=0`, capture `wb_data`; otherwise capture `rf_dataX`. `rsX==0` always captures 0.
- Immediate is sign-extended from `instr[31]`:
  - I: JALR, LOAD, OP-IMM, SYSTEM
  - S: STORE
  - B: BRANCH, bit0=0
  - U: LUI, AUIPC, low 12 bits 0
  - J: JAL, bit0=0
  - Any other opcode: 0.
- `out_rd_we`=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, with `rd`!=0.

## Timing
- Latency: one cycle from accept to `out_valid`.
- Outputs are registered, except `in_ready`, `rs1`, `rs2`.
- Reset: every output register is 0, including `out_valid`. `in_ready` is 0 while `reset_n` is low.
- Load-use: exactly one bubble cycle when `out_ready` is held at 1. The dependent instruction is accepted on the following cycle, after the load has left the stage.
- Backpressure: while `out_valid && !out_ready`, all outputs stay stable and `in_ready` is 0.
- `flush` together with `in_valid`: the instruction is not accepted, and upstream must also drop it.
- `flush` together with `reset_n` low: reset wins; the result is identical.
- WB write and read of the same register in the same cycle: the bypass gives the new value.

## Configuration
- `OPERAND_STAGE_ILLEGAL_DETECT_EN`
  - Defined: `out_illegal`=1 when `instr[1:0]!=2'b11` or the opcode is not one of the eleven RV32I opcodes. The instruction still flows through, with `out_rd_we`=0 and `out_is_load`=0.
  - Undefined: `out_illegal` is tied to 0 and no check logic is built.

## Structure
- `rv32i_pkg` holds:
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM)
  - `imm_type_e` enum (I, S, B, U, J, NONE)
- Sub-module `imm_gen`: combinational, takes `instr` and produces `imm`. It is reused by the branch unit.

## Test plan
- Accept `addi x1,x0,5` (0x00500093) with `out_ready`=1 -> next cycle `out_valid`=1, `out_imm`=5, `out_rd`=1, `out_rd_we`=1, `out_rs1_val`=0.
- `add x4,x3,x3` with `rf_data`=0 and WB writing x3=0xDEADBEEF in the same cycle -> `out_rs1_val`=`out_rs2_val`=0xDEADBEEF.
- `lw x5,0(x1)` then `add x6,x5,x0` back-to-back -> `in_ready`=0 for one cycle, one `out_valid`=0 bubble, then the add issues.
- `out_ready`=0 for 3 cycles holding `sw` (imm -4) -> outputs stable, `out_imm`=0xFFFFFFFC, `in_ready`=0.
- `flush` asserted while holding an instruction and `in_valid`=1 -> next cycle `out_valid`=0, nothing accepted.
- Instruction 0x00000000 -> `out_illegal`=1 and `out_rd_we`=0 with the macro defined; `out_illegal`=0 without it.
